// File: rtl/sram_pkg.sv
// Shared definitions for the banked byte-lane SRAM.
//   sram_state_e : controller states (reset hold, zero-fill, serving requests)
//   lane_bits()  : number of address bits that select a byte lane
//   row_bits()   : number of address bits that select a row inside one bank
//   lane_rotate(): rotate a word by whole byte lanes (lane i <- lane i+shift)
package sram_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_INIT  = 2'd1,
        S_READY = 2'd2
    } sram_state_e;

    // Widest word lane_rotate can handle; callers cast to their own width.
    localparam int unsigned MAX_LANES = 64;
    localparam int unsigned MAX_WIDTH = 8 * MAX_LANES;

    // Address split for the default 32-bit / 13-bit configuration.
    localparam int unsigned LANE_BITS = $clog2(4);
    localparam int unsigned ROW_BITS  = 13 - LANE_BITS;

    function automatic int unsigned lane_bits(input int unsigned num_lanes);
        return $clog2(num_lanes);
    endfunction

    function automatic int unsigned row_bits(input int unsigned addr_width,
                                             input int unsigned num_lanes);
        return addr_width - $clog2(num_lanes);
    endfunction

    // Output lane i takes input lane (i + shift) mod nlanes; nlanes is a
    // power of two so the modulo is a mask. Lanes above nlanes are zero.
    function automatic logic [MAX_WIDTH-1:0] lane_rotate(input logic [MAX_WIDTH-1:0] data,
                                                         input int unsigned           shift,
                                                         input int unsigned           nlanes);
        logic [MAX_WIDTH-1:0] res;
        int unsigned          src;
        res = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < nlanes) begin
                src            = (i + shift) & (nlanes - 32'd1);
                res[8*i +: 8]  = data[8*src +: 8];
            end else begin
                res[8*i +: 8]  = 8'h00;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_byte_bank.sv
// One byte-wide SRAM bank: one write port and one synchronous read port
// sharing a row address (reads and writes never occur in the same cycle).
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset of the read-data register only;
//             memory contents are never reset
//   we_i    : write enable
//   re_i    : read enable; rdata_o updates on the next edge, otherwise holds
//   addr_i  : row address
//   wdata_i : byte to write
//   rdata_o : registered read byte
module sram_byte_bank
    import sram_pkg::*;
#(
    parameter int ROW_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [ROW_W-1:0] addr_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [2**ROW_W];
    logic [7:0] rdata_q;

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Synchronous read port; holds its value between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_banked_bytelane.sv
// Byte-addressed, byte-masked SRAM built from NUM_WMASKS single-byte banks.
// Lane i of a request addresses byte (req_addr + i) mod 2**ADDR_WIDTH, so any
// alignment works and accesses at the top of memory wrap to byte 0.
//   clk, rst                 : clock and synchronous active-high reset
//   req_valid / req_ready    : request handshake (accept on valid && ready)
//   req_we, req_wmask        : write select and per-lane write enables
//   req_addr                 : byte address of lane 0
//   req_wdata                : write data, lane i = bits [8i+7:8i]
//   rsp_valid / rsp_rdata    : read response, READ_LATENCY cycles after accept,
//                              single-cycle pulse; rsp_rdata holds otherwise
// With IZERO=1 every reset is followed by a zero-fill pass over all rows
// during which req_ready stays low.
module sram_banked_bytelane
    import sram_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    NUM_WMASKS   = DATA_WIDTH / 8,
    parameter int    ADDR_WIDTH   = 13,
    parameter int    READ_LATENCY = 1,
    parameter int    IZERO        = 0,
    parameter string IFILE        = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    localparam int LANE_W = int'(lane_bits(NUM_WMASKS));
    localparam int ROW_W  = int'(row_bits(ADDR_WIDTH, NUM_WMASKS));

    sram_state_e state_q, state_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;

    logic                  accept_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [LANE_W-1:0]     lane_s;
    logic [ROW_W-1:0]      row_s;
    logic [ROW_W-1:0]      row_inc_s;
    logic [DATA_WIDTH-1:0] wdata_rot_s;
    logic [DATA_WIDTH-1:0] rdata_rot_s;

    logic [NUM_WMASKS-1:0]            bank_we_s;
    logic                             bank_re_s;
    logic [NUM_WMASKS-1:0][ROW_W-1:0] bank_addr_s;
    logic [NUM_WMASKS-1:0][7:0]       bank_wdata_s;
    logic [NUM_WMASKS-1:0][7:0]       bank_rdata_s;

    logic [READ_LATENCY-1:0] vld_q;
    logic [LANE_W-1:0]       lane_q;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // State and zero-fill row counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Next-state logic: zero-fill walks every row once, then serve requests.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            S_RESET: begin
                row_cnt_d = '0;
                if (IZERO != 0) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_READY;
                end
            end
            S_INIT: begin
                if (row_cnt_q == {ROW_W{1'b1}}) begin
                    state_d   = S_READY;
                    row_cnt_d = '0;
                end else begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d   = S_RESET;
                row_cnt_d = '0;
            end
        endcase
    end

    assign req_ready = (state_q == S_READY);

    // ------------------------------------------------------------------
    // Request decode and lane/bank mapping
    // ------------------------------------------------------------------

    assign accept_s  = req_valid && req_ready;
    assign wr_s      = accept_s && req_we;
    assign rd_s      = accept_s && !req_we;
    assign lane_s    = req_addr[LANE_W-1:0];
    assign row_s     = req_addr[ADDR_WIDTH-1:LANE_W];
    // Lanes that spill past the last bank land in the next row; at the top
    // of memory this wraps to row 0, which gives the byte-0 wrap-around.
    assign row_inc_s = row_s + ROW_W'(1);

    // Bank b receives request lane (b - lane_s) mod NUM_WMASKS.
    assign wdata_rot_s = DATA_WIDTH'(lane_rotate(MAX_WIDTH'(req_wdata),
                                                 32'(NUM_WMASKS) - 32'(lane_s),
                                                 32'(NUM_WMASKS)));

    // Per-bank control: zero-fill overrides request traffic.
    always_comb begin
        bank_we_s    = '0;
        bank_re_s    = 1'b0;
        bank_addr_s  = '0;
        bank_wdata_s = '0;
        if (state_q == S_INIT) begin
            for (int b = 0; b < NUM_WMASKS; b++) begin
                bank_we_s[b]    = 1'b1;
                bank_addr_s[b]  = row_cnt_q;
                bank_wdata_s[b] = 8'h00;
            end
        end else begin
            bank_re_s = rd_s;
            for (int b = 0; b < NUM_WMASKS; b++) begin
                bank_we_s[b]    = wr_s && req_wmask[LANE_W'(b) - lane_s];
                bank_addr_s[b]  = (LANE_W'(b) >= lane_s) ? row_s : row_inc_s;
                bank_wdata_s[b] = wdata_rot_s[8*b +: 8];
            end
        end
    end

    for (genvar b = 0; b < NUM_WMASKS; b++) begin : g_bank
        sram_byte_bank #(
            .ROW_W (ROW_W)
        ) u_bank (
            .clk_i   (clk),
            .rst_i   (rst),
            .we_i    (bank_we_s[b]),
            .re_i    (bank_re_s),
            .addr_i  (bank_addr_s[b]),
            .wdata_i (bank_wdata_s[b]),
            .rdata_o (bank_rdata_s[b])
        );
    end

    // ------------------------------------------------------------------
    // Read response pipeline
    // ------------------------------------------------------------------

    // Valid shift register and the lane offset needed to un-rotate the
    // bank outputs; lane_q only changes on a new read so data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            lane_q <= '0;
        end else begin
            vld_q[0] <= rd_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            if (rd_s) begin
                lane_q <= lane_s;
            end else begin
                lane_q <= lane_q;
            end
        end
    end

    assign rdata_rot_s = DATA_WIDTH'(lane_rotate(MAX_WIDTH'(bank_rdata_s),
                                                 32'(lane_q),
                                                 32'(NUM_WMASKS)));

    assign rsp_valid = vld_q[READ_LATENCY-1];

    if (READ_LATENCY == 1) begin : g_lat1
        assign rsp_rdata = rdata_rot_s;
    end else begin : g_latn
        logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY-1];

        // Extra latency stages; each loads only when its read is passing,
        // so the final stage holds between responses.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < READ_LATENCY-1; k++) begin
                    pipe_q[k] <= '0;
                end
            end else begin
                if (vld_q[0]) begin
                    pipe_q[0] <= rdata_rot_s;
                end
                for (int k = 1; k < READ_LATENCY-1; k++) begin
                    if (vld_q[k]) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end
        end

        assign rsp_rdata = pipe_q[READ_LATENCY-2];
    end

endmodule
